// File: rtl/xbar_pkg.sv
// xbar_pkg: crossbar types and constants shared by the request routers
package xbar_pkg;
  localparam int ERR_CNT_W = 8;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} wr_state_e;
endpackage

// File: rtl/wr_sel_decode.sv
// wr_sel_decode: binary slave select to one-hot vector plus out-of-range flag
module wr_sel_decode #(
  parameter int N_SLAVES = 4,
  parameter int SEL_W = $clog2(N_SLAVES)
) (
  input  logic [SEL_W-1:0]    sel,
  output logic [N_SLAVES-1:0] one_hot,
  output logic                out_of_range
);
  always_comb begin
    out_of_range = 32'(sel) >= N_SLAVES;
    for (int i = 0; i < N_SLAVES; i++) one_hot[i] = 32'(sel) == i;
  end
endmodule

// File: rtl/wr_req_router.sv
// wr_req_router: steers one held write request to the selected slave port and
// returns a registered completion pulse with decode/timeout error status
module wr_req_router
  import xbar_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W = $clog2(N_SLAVES),
  parameter int TIMEOUT = 256
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [SEL_W-1:0]           i_sel,
  input  logic [ADDR_W-1:0]          i_addr,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic                       i_req,
  output logic                       o_ack,
  output logic                       o_err,
  output logic [N_SLAVES-1:0]        o_req,
  output logic [N_SLAVES*ADDR_W-1:0] o_addr,
  output logic [N_SLAVES*DATA_W-1:0] o_wdata,
  input  logic [N_SLAVES-1:0]        i_ack,
  output logic [ERR_CNT_W-1:0]       o_err_cnt
);
  localparam int CNT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } wr_req_t;
  wr_state_e state, nxt_state;
  wr_req_t lat;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [N_SLAVES-1:0] in_hot, lat_hot, req_d;
  logic [N_SLAVES*ADDR_W-1:0] addr_d;
  logic [N_SLAVES*DATA_W-1:0] wdata_d;
  logic in_oor, lat_oor, accept, sel_ack, expire, stay, fin, done_err;
  wr_sel_decode #(.N_SLAVES(N_SLAVES), .SEL_W(SEL_W)) u_in_dec (
    .sel(i_sel), .one_hot(in_hot), .out_of_range(in_oor)
  );
  wr_sel_decode #(.N_SLAVES(N_SLAVES), .SEL_W(SEL_W)) u_lat_dec (
    .sel(lat.sel), .one_hot(lat_hot), .out_of_range(lat_oor)
  );
  assign accept = state == IDLE && i_req;
  assign sel_ack = state == BUSY && !lat_oor && |(i_ack & lat_hot);
  assign expire = TIMEOUT != 0 && 32'(cnt) == TIMEOUT - 1;
  always_comb begin
    nxt_state = state;
    nxt_cnt = cnt;
    if (accept) begin
      nxt_state = in_oor ? DONE : BUSY;
      nxt_cnt = '0;
    end else if (state == BUSY) begin
      nxt_state = sel_ack || expire ? DONE : BUSY;
      nxt_cnt = cnt + 1'b1;
    end else if (state != IDLE) begin
      nxt_state = IDLE;
    end
  end
  assign stay = state == BUSY && nxt_state == BUSY;
  assign fin = nxt_state == DONE && state != DONE;
  // an ack sampled on the last timeout cycle still counts as success
  assign done_err = accept ? in_oor : state == BUSY && !sel_ack && expire;
  for (genvar g = 0; g < N_SLAVES; g++) begin : g_port
    assign req_d[g] = stay ? lat_hot[g] : accept && !in_oor && in_hot[g];
    assign addr_d[g*ADDR_W +: ADDR_W] = req_d[g] ? (stay ? lat.addr : i_addr) : '0;
    assign wdata_d[g*DATA_W +: DATA_W] = req_d[g] ? (stay ? lat.wdata : i_wdata) : '0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      lat <= '0;
      cnt <= '0;
      o_req <= '0;
      o_addr <= '0;
      o_wdata <= '0;
      o_ack <= 1'b0;
      o_err <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      state <= nxt_state;
      cnt <= nxt_cnt;
      if (accept) lat <= '{sel: i_sel, addr: i_addr, wdata: i_wdata};
      o_req <= req_d;
      o_addr <= addr_d;
      o_wdata <= wdata_d;
      o_ack <= fin;
      o_err <= fin && done_err;
      if (fin && done_err && o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
    end
  end
endmodule
